ifetch_queue: RTL and testbench

- Instruction fetch stage directly upstream of the decode/immediate-generation stage.
- Owns the PC and issues sequential word fetches to instruction memory. Buffers returned instructions in a small in-order queue and presents them to decode over a valid/ready handshake.
- Each queued instruction carries its PC and a 3-bit imm_sel pre-decoded from the opcode. The immediate generator consumes that field directly.
- Redirects (branch, jal, jalr) flush the queue and restart fetch at the new PC.

---
 rtl/proc_pkg.sv | 43 ++++
 rtl/ifetch_fifo.sv | 60 ++++++
 rtl/ifetch_queue.sv | 123 ++++++++++++
 tb/tb_ifetch_queue.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared opcode constants, immediate-format encodings and the fetch-queue entry
// layout used by fetch, decode and the immediate generator.
package proc_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_LD   = 3'b001,
    IMM_S    = 3'b010,
    IMM_JALR = 3'b011,
    IMM_J    = 3'b100,
    IMM_B    = 3'b110,
    IMM_BAD  = 3'b111
  } imm_sel_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    imm_sel_e    imm_sel;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // Pre-decode so the immediate generator does not sit behind an opcode compare.
  function automatic imm_sel_e decode_imm_sel(input logic [6:0] opcode);
    case (opcode)
      OP_IMM:    return IMM_I;
      OP_LOAD:   return IMM_LD;
      OP_STORE:  return IMM_S;
      OP_JALR:   return IMM_JALR;
      OP_JAL:    return IMM_J;
      OP_BRANCH: return IMM_B;
      default:   return IMM_BAD;
    endcase
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// In-order DEPTH-entry synchronous FIFO with a single-cycle flush; the head is
// visible combinationally so a newly written entry is presentable the next cycle.
module ifetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 67,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_ptr_reg] <= wr_data;
    end
  end

  always_comb begin
    count_next = count_reg;
    if (wr_en && !rd_en) begin
      count_next = count_reg + CNT_W'(1);
    end else if (rd_en && !wr_en) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_next;
    end
  end

  assign rd_data = mem_reg[rd_ptr_reg];
  assign count   = count_reg;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: owns the PC, issues credit-limited sequential fetches,
// queues responses with PC and pre-decoded imm_sel, and flushes on redirect.
module ifetch_queue
  import proc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [2:0]  out_imm_sel
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [31:0]      fetch_pc_reg, fetch_pc_next;
  logic [31:0]      resp_pc_reg, resp_pc_next;
  logic [CNT_W-1:0] inflight_reg, inflight_next;
  logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W:0]   credit_used;
  logic             credit_ok;
  logic             req_fire;
  logic             enq;
  logic             deq;
  fetch_entry_t     wr_entry;
  fetch_entry_t     head_entry;
  logic [ENTRY_W-1:0] head_bits;

  // Queue entries plus outstanding requests never exceed DEPTH, so every
  // response is guaranteed a slot.
  assign credit_used    = {1'b0, occupancy} + {1'b0, inflight_reg};
  assign credit_ok      = credit_used < (CNT_W+1)'(DEPTH);
  assign imem_req_valid = rst_n && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign enq = rst_n && imem_resp_valid && !redirect_valid && (drop_cnt_reg == '0);
  assign out_valid = rst_n && (occupancy != '0);
  assign deq = out_valid && out_ready;

  assign wr_entry = '{
    inst:    imem_resp_data,
    pc:      resp_pc_reg,
    imm_sel: decode_imm_sel(imem_resp_data[6:0])
  };

  ifetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect_valid),
    .wr_en   (enq),
    .wr_data (wr_entry),
    .rd_en   (deq),
    .rd_data (head_bits),
    .count   (occupancy)
  );

  assign head_entry  = fetch_entry_t'(head_bits);
  assign out_inst    = out_valid ? head_entry.inst : 32'h0;
  assign out_pc      = out_valid ? head_entry.pc : 32'h0;
  assign out_imm_sel = out_valid ? head_entry.imm_sel : 3'b000;

  always_comb begin
    inflight_next = inflight_reg;
    case ({req_fire, imem_resp_valid})
      2'b10:   inflight_next = inflight_reg + ONE;
      2'b01:   inflight_next = inflight_reg - ONE;
      default: inflight_next = inflight_reg;
    endcase

    fetch_pc_next = fetch_pc_reg;
    resp_pc_next  = resp_pc_reg;
    drop_cnt_next = drop_cnt_reg;
    if (redirect_valid) begin
      // Everything still outstanding after this edge belongs to the old path.
      fetch_pc_next = redirect_pc;
      resp_pc_next  = redirect_pc;
      drop_cnt_next = imem_resp_valid ? (inflight_reg - ONE) : inflight_reg;
    end else begin
      if (req_fire) begin
        fetch_pc_next = fetch_pc_reg + 32'd4;
      end
      if (imem_resp_valid) begin
        if (drop_cnt_reg != '0) begin
          drop_cnt_next = drop_cnt_reg - ONE;
        end else begin
          resp_pc_next = resp_pc_reg + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_reg <= RESET_PC;
      resp_pc_reg  <= RESET_PC;
      inflight_reg <= '0;
      drop_cnt_reg <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      resp_pc_reg  <= resp_pc_next;
      inflight_reg <= inflight_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: transaction-level reference model with a
// latency-programmable in-order memory, directed corner cases and random traffic.
module tb_ifetch_queue;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [2:0]  out_imm_sel;

  always #5 clk = ~clk;

  ifetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_inst        (out_inst),
    .out_pc          (out_pc),
    .out_imm_sel     (out_imm_sel)
  );

  typedef struct { logic [31:0] addr; bit stale; } req_t;
  typedef struct { logic [31:0] addr; int due; } mem_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct { logic [31:0] inst; logic [2:0] imm; } dec_vec_t;

  req_t  outst[$];     // requests the model believes are outstanding
  mem_t  pend[$];      // memory-side pipeline
  ent_t  outq[$];      // expected queue contents, head first
  logic [31:0] req_log[$];
  logic [31:0] override_mem [logic [31:0]];
  logic [31:0] m_fetch_pc = RESET_PC;

  int errors = 0, checks = 0, cyc = 0;
  int lat = 1, ordy_pct = 100, mrdy_pct = 100;
  bit rst_req = 1'b1, redir_req = 1'b0;
  logic [31:0] redir_target = 32'h0;

  bit s_req_valid, s_out_valid, s_deq, s_resp;
  logic [31:0] s_req_addr, s_pc;
  logic [2:0] s_imm;
  int s_drop, s_occ, s_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [2:0] ref_imm(input logic [6:0] op);
    case (op)
      7'h13:   return 3'b000;
      7'h03:   return 3'b001;
      7'h23:   return 3'b010;
      7'h67:   return 3'b011;
      7'h6F:   return 3'b100;
      7'h63:   return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  // Default memory contents mix all opcode classes and encode the address.
  function automatic logic [31:0] memword(input logic [31:0] addr);
    logic [6:0] op;
    if (override_mem.exists(addr)) return override_mem[addr];
    case (addr[4:2])
      3'd0: op = 7'h13; 3'd1: op = 7'h03; 3'd2: op = 7'h23; 3'd3: op = 7'h67;
      3'd4: op = 7'h6F; 3'd5: op = 7'h63; 3'd6: op = 7'h33; default: op = 7'h37;
    endcase
    return {addr[26:2], op};
  endfunction

  task automatic step();
    bit rv, rsp, ordy, mrdy, exp_req, exp_ov;
    logic [31:0] rpc, rdata;
    ent_t h;
    req_t o;
    int stale;
    @(negedge clk);
    rst_n = !rst_req;
    rv = redir_req; rpc = redir_target; redir_req = 1'b0;
    redirect_valid = rv; redirect_pc = rpc;
    ordy = ($urandom_range(99) < ordy_pct); out_ready = ordy;
    mrdy = ($urandom_range(99) < mrdy_pct); imem_req_ready = mrdy;
    rsp = 1'b0; rdata = $urandom;
    if (pend.size() > 0) begin
      if (pend[0].due <= cyc) begin
        rsp = 1'b1;
        rdata = memword(pend[0].addr);
      end
    end
    imem_resp_valid = rsp; imem_resp_data = rdata;
    #1;
    exp_req = rst_n && !rv && (outq.size() + outst.size() < DEPTH);
    exp_ov  = rst_n && (outq.size() > 0);
    check("req_valid", imem_req_valid, exp_req);
    if (exp_req) check("req_addr", imem_req_addr, m_fetch_pc);
    check("out_valid", out_valid, exp_ov);
    if (exp_ov) h = outq[0]; else h = '{pc: 32'h0, inst: 32'h0};
    check("out_pc", out_pc, h.pc);
    check("out_inst", out_inst, h.inst);
    check("out_imm_sel", out_imm_sel, exp_ov ? ref_imm(h.inst[6:0]) : 3'b000);
    s_occ = int'(dut.occupancy);
    s_drop = int'(dut.drop_cnt_reg);
    if (rst_n) begin
      stale = 0;
      foreach (outst[i]) if (outst[i].stale) stale++;
      check("drop_cnt", s_drop, stale);
      check("inflight", dut.inflight_reg, outst.size());
      check("inv_credit", (s_occ + int'(dut.inflight_reg)) <= DEPTH, 1);
      check("inv_drop", s_drop <= int'(dut.inflight_reg), 1);
    end
    s_req_valid = imem_req_valid; s_req_addr = imem_req_addr;
    s_out_valid = out_valid; s_deq = out_valid && out_ready;
    s_pc = out_pc; s_imm = out_imm_sel; s_resp = rsp; s_cyc = cyc;
    if (imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
    if (out_valid && out_ready)
      $display("cyc=%0d deq pc=%h inst=%h imm_sel=%b", cyc, out_pc, out_inst, out_imm_sel);
    @(posedge clk);
    if (!rst_n) begin
      outst.delete(); pend.delete(); outq.delete();
      m_fetch_pc = RESET_PC;
    end else begin
      if (exp_ov && ordy) void'(outq.pop_front());
      if (rsp) begin
        void'(pend.pop_front());
        o = outst.pop_front();
        if (!o.stale && !rv) outq.push_back('{pc: o.addr, inst: rdata});
      end
      if (rv) begin
        outq.delete();
        foreach (outst[i]) outst[i].stale = 1'b1;
        m_fetch_pc = rpc;
      end
      if (exp_req && mrdy) begin
        outst.push_back('{addr: m_fetch_pc, stale: 1'b0});
        pend.push_back('{addr: m_fetch_pc, due: cyc + lat});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    repeat (2) step();
    rst_req = 1'b0;
  endtask

  task automatic collect_pcs(input string name, input logic [31:0] start, input int n);
    int k = 0;
    int budget = 60;
    while (k < n && budget > 0) begin
      step();
      budget--;
      if (s_out_valid && s_deq) begin
        check(name, s_pc, start + 32'(4 * k));
        k++;
      end
    end
    if (k < n) check({name, "_timeout"}, k, n);
  endtask

  dec_vec_t dec_tab[7];

  initial begin
    int hs, budget, found;
    logic [31:0] r;

    dec_tab[0] = '{inst: 32'h00A00093, imm: 3'b000};
    dec_tab[1] = '{inst: 32'h0040A103, imm: 3'b001};
    dec_tab[2] = '{inst: 32'h0020A223, imm: 3'b010};
    dec_tab[3] = '{inst: 32'h000080E7, imm: 3'b011};
    dec_tab[4] = '{inst: 32'h008000EF, imm: 3'b100};
    dec_tab[5] = '{inst: 32'h00208463, imm: 3'b110};
    dec_tab[6] = '{inst: 32'h00000033, imm: 3'b111};

    // Reset and stream with a 1-cycle memory.
    rst_req = 1'b1;
    step();
    check("rst_out_valid", s_out_valid, 0);
    check("rst_req_valid", s_req_valid, 0);
    step();
    rst_req = 1'b0;
    req_log.delete();
    step();
    check("first_req_valid", s_req_valid, 1);
    check("first_req_addr", s_req_addr, RESET_PC);
    hs = s_cyc;
    budget = 10;
    do begin step(); budget--; end while (!s_out_valid && budget > 0);
    check("first_latency", s_cyc - hs, 2);
    check("first_out_pc", s_pc, 32'h0);
    collect_pcs("stream_pc", 32'h4, 2);
    check("req_log_size_ok", req_log.size() >= 3, 1);
    if (req_log.size() >= 3) begin
      check("req0", req_log[0], 32'h0);
      check("req1", req_log[1], 32'h4);
      check("req2", req_log[2], 32'h8);
    end

    // imm_sel decode table.
    foreach (dec_tab[i]) override_mem[32'h200 + 32'(4 * i)] = dec_tab[i].inst;
    redir_target = 32'h200; redir_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      found = 0;
      for (int b = 0; b < 20 && found == 0; b++) begin
        step();
        if (s_out_valid && s_deq && s_pc == 32'h200 + 32'(4 * i)) found = 1;
      end
      check("dec_found", found, 1);
      if (found != 0) check("dec_imm_sel", s_imm, dec_tab[i].imm);
    end
    override_mem.delete();

    // Backpressure: queue fills to DEPTH and holds its head.
    ordy_pct = 0;
    do_reset();
    repeat (10) step();
    check("bp_valid", s_out_valid, 1);
    check("bp_head_pc", s_pc, 32'h0);
    check("bp_req_valid", s_req_valid, 0);
    check("bp_occupancy", s_occ, DEPTH);
    ordy_pct = 100;
    collect_pcs("bp_drain", 32'h0, 3);

    // Redirect with two requests outstanding on a 3-cycle memory.
    lat = 3;
    do_reset();
    step(); check("rd_req0", s_req_valid, 1);
    step(); check("rd_req1", s_req_valid, 1);
    redir_target = 32'h100; redir_req = 1'b1;
    step(); check("rd_no_req", s_req_valid, 0);
    step(); check("rd_drop2", s_drop, 2);
    collect_pcs("rd_pc", 32'h100, 2);
    check("rd_drop0", s_drop, 0);

    // Redirect coinciding with a live response and a dequeue.
    lat = 1;
    do_reset();
    step(); step();
    redir_target = 32'h300; redir_req = 1'b1;
    step();
    check("sim_pre_valid", s_out_valid, 1);
    check("sim_pre_resp", s_resp, 1);
    check("sim_no_req", s_req_valid, 0);
    step();
    check("sim_empty", s_out_valid, 0);
    check("sim_drop", s_drop, 0);
    check("sim_req_addr", s_req_addr, 32'h300);

    // PC wrap, then reset with a full queue.
    redir_target = 32'hFFFF_FFFC; redir_req = 1'b1;
    collect_pcs("wrap_pc", 32'hFFFF_FFFC, 2);
    ordy_pct = 0;
    repeat (8) step();
    check("full_before_rst", s_occ, DEPTH);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    step();
    check("post_rst_valid", s_out_valid, 0);
    check("post_rst_req_valid", s_req_valid, 1);
    check("post_rst_req_addr", s_req_addr, RESET_PC);
    ordy_pct = 100;

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) begin
        lat = $urandom_range(4, 1);
        ordy_pct = $urandom_range(100, 30);
        mrdy_pct = $urandom_range(100, 30);
      end
      if ($urandom_range(99) < 4) begin
        r = $urandom;
        if ($urandom_range(3) == 0) r = 32'hFFFF_FFF0 | r[3:0];
        r[1:0] = 2'b00;
        redir_target = r; redir_req = 1'b1;
      end
      rst_req = ($urandom_range(199) == 0);
      step();
    end
    rst_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
